// File: rtl/vga_sync_gen.sv
// vga_sync_gen: timing decoder for the 640x480@60 VGA path.
// Decodes the upstream h/v pixel counts into registered hsync/vsync, the
// video_on blanking gate, pixel coordinates, line/frame strobes and a frame
// counter. Two small FSMs track the horizontal and vertical timing regions.
// Optional feature: define VGA_SYNC_CHECK_EN to build the count-sequence
// checker that drives the sticky timing_err flag (otherwise timing_err = 0).
module vga_sync_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count,
  output logic       timing_err
);

  // Region start points; anything at or beyond *_TOT is out of range.
  localparam logic [9:0] H_FP_START   = 10'(H_VIS);
  localparam logic [9:0] H_SYNC_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_BP_START   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] H_TOT        = 10'(H_VIS + H_FP + H_SYNC + H_BP);
  localparam logic [9:0] V_FP_START   = 10'(V_VIS);
  localparam logic [9:0] V_SYNC_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_BP_START   = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] V_TOT        = 10'(V_VIS + V_FP + V_SYNC + V_BP);

  typedef enum logic [1:0] {ST_H_VIS, ST_H_FP, ST_H_SYNC, ST_H_BP} h_state_t;
  typedef enum logic [1:0] {ST_V_VIS, ST_V_FP, ST_V_SYNC, ST_V_BP} v_state_t;

  h_state_t   h_state_q, h_state_d;
  v_state_t   v_state_q, v_state_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // Next H/V state: decoded from the sampled counts on enabled cycles, held otherwise.
  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    if (pix_en) begin
      if (h_count < H_FP_START)        h_state_d = ST_H_VIS;
      else if (h_count < H_SYNC_START) h_state_d = ST_H_FP;
      else if (h_count < H_BP_START)   h_state_d = ST_H_SYNC;
      else                             h_state_d = ST_H_BP;  // includes out-of-range
      if (v_count < V_FP_START)        v_state_d = ST_V_VIS;
      else if (v_count < V_SYNC_START) v_state_d = ST_V_FP;
      else if (v_count < V_BP_START)   v_state_d = ST_V_SYNC;
      else                             v_state_d = ST_V_BP;  // includes out-of-range
    end else begin
      h_state_d = h_state_q;
      v_state_d = v_state_q;
    end
  end

  // Output next-values derived from the next FSM states; everything holds while pix_en=0.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    frame_count_d = frame_count_q;
    if (pix_en) begin
      hsync_d       = (h_state_d != ST_H_SYNC);
      vsync_d       = (v_state_d != ST_V_SYNC);
      video_on_d    = (h_state_d == ST_H_VIS) && (v_state_d == ST_V_VIS);
      pixel_x_d     = video_on_d ? h_count : 10'd0;
      pixel_y_d     = video_on_d ? v_count : 10'd0;
      line_start_d  = (h_count == 10'd0);
      frame_start_d = (h_count == 10'd0) && (v_count == 10'd0);
      if (frame_start_d) begin
        frame_count_d = frame_count_q + 8'd1;  // wraps 255 -> 0 naturally
      end else begin
        frame_count_d = frame_count_q;
      end
    end else begin
      hsync_d = hsync_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_state_q     <= ST_H_BP;
      v_state_q     <= ST_V_BP;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      h_state_q     <= h_state_d;
      v_state_q     <= v_state_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

`ifdef VGA_SYNC_CHECK_EN
  logic [9:0] prev_h_q, prev_h_d;
  logic [9:0] prev_v_q, prev_v_d;
  logic       primed_q, primed_d;
  logic       timing_err_q, timing_err_d;
  logic       seq_ok_s;

  // Sequence check: the new sample must be the successor of the previous one.
  always_comb begin
    prev_h_d     = prev_h_q;
    prev_v_d     = prev_v_q;
    primed_d     = primed_q;
    timing_err_d = timing_err_q;
    seq_ok_s     = 1'b1;
    if (prev_h_q == H_TOT - 10'd1) begin
      seq_ok_s = (h_count == 10'd0) &&
                 (v_count == ((prev_v_q == V_TOT - 10'd1) ? 10'd0 : 10'(prev_v_q + 10'd1)));
    end else begin
      seq_ok_s = (h_count == 10'(prev_h_q + 10'd1)) && (v_count == prev_v_q);
    end
    if (pix_en) begin
      prev_h_d = h_count;
      prev_v_d = v_count;
      primed_d = 1'b1;
      // The first sample after reset only primes the history.
      if (primed_q && (!seq_ok_s || (h_count >= H_TOT) || (v_count >= V_TOT))) begin
        timing_err_d = 1'b1;
      end else begin
        timing_err_d = timing_err_q;
      end
    end else begin
      primed_d = primed_q;
    end
  end

  // Checker history and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_h_q     <= 10'd0;
      prev_v_q     <= 10'd0;
      primed_q     <= 1'b0;
      timing_err_q <= 1'b0;
    end else begin
      prev_h_q     <= prev_h_d;
      prev_v_q     <= prev_v_d;
      primed_q     <= primed_d;
      timing_err_q <= timing_err_d;
    end
  end

  assign timing_err = timing_err_q;
`else
  assign timing_err = 1'b0;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Testbench for vga_sync_gen: a per-cycle behavioural model derived from the
// 640x480 timing rules, plus directed vectors with literal expectations.
module tb_vga_sync_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic [9:0] h_count;
  logic [9:0] v_count;
  logic       hsync, vsync, video_on, line_start, frame_start, timing_err;
  logic [9:0] pixel_x, pixel_y;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_gen dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .h_count(h_count), .v_count(v_count),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic       e_hsync, e_vsync, e_video, e_ls, e_fs, e_err;
  logic [9:0] e_px, e_py;
  int         e_fc;
  int         m_prev_h, m_prev_v;
  bit         m_primed;

  always @(posedge clk or negedge rst_n) begin
    int h, v;
    bit vis, legal;
    if (!rst_n) begin
      e_hsync <= 1'b1; e_vsync <= 1'b1; e_video <= 1'b0;
      e_px <= 10'd0; e_py <= 10'd0; e_ls <= 1'b0; e_fs <= 1'b0;
      e_fc <= 0; e_err <= 1'b0; m_primed <= 1'b0;
      m_prev_h <= 0; m_prev_v <= 0;
    end else if (pix_en) begin
      h = int'(h_count);
      v = int'(v_count);
      vis = (h < 640) && (v < 480);
      e_hsync <= !(h >= 656 && h <= 751);
      e_vsync <= !(v >= 490 && v <= 491);
      e_video <= vis;
      e_px    <= vis ? h_count : 10'd0;
      e_py    <= vis ? v_count : 10'd0;
      e_ls    <= (h == 0);
      e_fs    <= (h == 0) && (v == 0);
      if (h == 0 && v == 0) e_fc <= (e_fc + 1) % 256;
`ifdef VGA_SYNC_CHECK_EN
      if (m_prev_h == 799)
        legal = (h == 0) && (v == ((m_prev_v == 524) ? 0 : m_prev_v + 1));
      else
        legal = (h == m_prev_h + 1) && (v == m_prev_v);
      if (m_primed && (!legal || h >= 800 || v >= 525)) e_err <= 1'b1;
`endif
      m_primed <= 1'b1;
      m_prev_h <= h;
      m_prev_v <= v;
    end
  end

  // Compare process: every falling edge, outputs against the model.
  always @(negedge clk) begin
    chk("m_hsync",      int'(hsync),       int'(e_hsync));
    chk("m_vsync",      int'(vsync),       int'(e_vsync));
    chk("m_video_on",   int'(video_on),    int'(e_video));
    chk("m_pixel_x",    int'(pixel_x),     int'(e_px));
    chk("m_pixel_y",    int'(pixel_y),     int'(e_py));
    chk("m_line_start", int'(line_start),  int'(e_ls));
    chk("m_frame_start",int'(frame_start), int'(e_fs));
    chk("m_frame_count",int'(frame_count), e_fc);
    chk("m_timing_err", int'(timing_err),  int'(e_err));
  end

  // Present one enabled sample and settle just after the capturing edge.
  task automatic step(input int h, input int v);
    @(negedge clk);
    h_count = 10'(h);
    v_count = 10'(v);
    pix_en  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pix_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int vs_low, vid_hi;

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; h_count = 10'd0; v_count = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_video_on", int'(video_on), 0);
    chk("rst_frame_count", int'(frame_count), 0);
    chk("rst_timing_err", int'(timing_err), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Line sweep at v=100.
    step(638, 100);
    step(639, 100); chk("h639_video", int'(video_on), 1); chk("h639_px", int'(pixel_x), 639);
                    chk("h639_py", int'(pixel_y), 100);
    step(640, 100); chk("h640_video", int'(video_on), 0); chk("h640_px", int'(pixel_x), 0);
    for (int h = 641; h <= 655; h++) step(h, 100);
    chk("h655_hsync", int'(hsync), 1);
    step(656, 100); chk("h656_hsync", int'(hsync), 0);
    for (int h = 657; h <= 751; h++) step(h, 100);
    chk("h751_hsync", int'(hsync), 0);
    step(752, 100); chk("h752_hsync", int'(hsync), 1);

    // Stall at h=656: outputs hold while the counts move underneath.
    step(656, 100); chk("stall_pre_hsync", int'(hsync), 0);
    @(negedge clk); pix_en = 1'b0; h_count = 10'd0; v_count = 10'd0;
    repeat (5) @(posedge clk);
    #1;
    chk("stall_hsync_held", int'(hsync), 0);
    chk("stall_no_line_start", int'(line_start), 0);
    chk("stall_no_frame_start", int'(frame_start), 0);
    step(0, 101);   chk("ls_pulse", int'(line_start), 1);
    @(negedge clk); pix_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("ls_held_in_stall", int'(line_start), 1);
    step(1, 101);   chk("ls_drop", int'(line_start), 0);

    // Vertical window: lines 476..495, full lines.
    vs_low = 0; vid_hi = 0;
    for (int v = 476; v <= 495; v++)
      for (int h = 0; h < 800; h++) begin
        step(h, v);
        if (!vsync) vs_low++;
        if (video_on) vid_hi++;
      end
    chk("vsync_low_clks", vs_low, 1600);
    chk("video_on_clks", vid_hi, 4 * 640);

    // Asynchronous reset mid-line, no clock edge needed.
    step(700, 200);
    chk("pre_rst_hsync", int'(hsync), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hsync", int'(hsync), 1);
    chk("async_rst_pixel_y", int'(pixel_y), 0);
    chk("async_rst_timing_err", int'(timing_err), 0);
    @(negedge clk); rst_n = 1'b1;

    // Frame counter wrap after 255 presets.
    for (int f = 0; f < 255; f++) begin
      step(799, 524);
      step(0, 0);
    end
    chk("fc_255", int'(frame_count), 255);
    step(799, 524); chk("pre_wrap_fs", int'(frame_start), 0);
    step(0, 0);
    chk("wrap_frame_start", int'(frame_start), 1);
    chk("wrap_line_start", int'(line_start), 1);
    chk("wrap_frame_count", int'(frame_count), 0);
    step(1, 0);
    chk("post_wrap_fs", int'(frame_start), 0);
    chk("post_wrap_ls", int'(line_start), 0);

    // Sequence checker.
    do_reset();
    step(10, 50); step(11, 50);
    chk("seq_ok_err", int'(timing_err), 0);
    step(13, 50);
`ifdef VGA_SYNC_CHECK_EN
    chk("seq_gap_err", int'(timing_err), 1);
    step(14, 50);
    chk("seq_sticky_err", int'(timing_err), 1);
`else
    chk("seq_gap_no_err", int'(timing_err), 0);
`endif
    do_reset();
    step(5, 60);
    step(900, 60);
    chk("oor_hsync", int'(hsync), 1);
    chk("oor_video", int'(video_on), 0);
    chk("oor_px", int'(pixel_x), 0);
`ifdef VGA_SYNC_CHECK_EN
    chk("oor_err", int'(timing_err), 1);
`else
    chk("oor_no_err", int'(timing_err), 0);
`endif
    step(300, 600);
    chk("oor_v_vsync", int'(vsync), 1);
    chk("oor_v_video", int'(video_on), 0);
    chk("oor_v_py", int'(pixel_y), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
